// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared instruction-memory geometry, fill value and loader state encoding
package imem_loader_pkg;
  localparam int IMEM_DEPTH = 128;
  localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in and instruction-memory write port out
interface imem_loader_if import imem_loader_pkg::*; #(parameter int ADDR_W = IMEM_ADDR_W) ();
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic in_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (output in_valid, in_data, in_last, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, in_last, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles little-endian bytes into 32-bit words
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        acc,
  input  logic        last,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        partial_on_last
);
  logic [1:0] byte_cnt;
  logic [23:0] sh;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      byte_cnt <= '0;
      sh <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      sh <= '0;
    end else if (acc) begin
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt != 2'd3) sh[{byte_cnt, 3'b000} +: 8] <= data;
    end
  // the fourth byte is taken straight from the input so the word is ready on its acceptance edge
  assign word = {data, sh};
  assign word_valid = acc && byte_cnt == 2'd3;
  assign partial_on_last = acc && last && byte_cnt != 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: clears instruction memory to NOP, then fills it from a byte stream while holding the CPU
module imem_loader import imem_loader_pkg::*; #(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            busy,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);
  state_t state;
  logic finish, acc, ovf, pk_acc, word_valid, partial;
  logic [31:0] word;
  assign acc = bus.in_valid && bus.in_ready;
  assign ovf = acc && word_count == (ADDR_W+1)'(DEPTH);
  // a word that ended the image is written first, then the FSM leaves LOAD on the following edge
  assign pk_acc = acc && !ovf && !finish;
  assign cpu_hold = busy;
  imem_loader_byte_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clr(start && (state == IDLE || state == DONE)),
    .acc(pk_acc),
    .last(bus.in_last),
    .data(bus.in_data),
    .word_valid(word_valid),
    .word(word),
    .partial_on_last(partial)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      finish <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      word_count <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= CLEAR;
            busy <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            word_count <= '0;
            bus.mem_we <= 1'b1;
            bus.mem_addr <= '0;
            bus.mem_wdata <= NOP_WORD;
          end
        CLEAR:
          if (bus.mem_addr == ADDR_W'(DEPTH-1)) begin
            state <= LOAD;
            bus.in_ready <= 1'b1;
          end else begin
            bus.mem_we <= 1'b1;
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end
        default: begin
          if (ovf || partial) err <= 1'b1;
          if (ovf || partial || finish) begin
            state <= DONE;
            finish <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            bus.in_ready <= 1'b0;
          end else if (word_valid) begin
            bus.mem_we <= 1'b1;
            bus.mem_addr <= word_count[ADDR_W-1:0];
            bus.mem_wdata <= word;
            word_count <= word_count + 1'b1;
            finish <= bus.in_last;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; every expected memory write is queued with its cycle, address and data
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, cpu_hold, done, err;
  logic [IMEM_ADDR_W:0] word_count;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [70:0] exp_q[$];
  imem_loader_if bus ();
  imem_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .busy(busy),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err),
    .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // writes are compared against the queue head: cycle, address and data together
  always @(negedge clk)
    if (!reset && bus.mem_we) begin
      if (exp_q.size() == 0) check("unexpected_write", {cyc, bus.mem_addr, bus.mem_wdata}, '0);
      else check("write", {cyc, bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start;
    for (int i = 0; i < IMEM_DEPTH; i++) exp_q.push_back({32'(cyc + 1 + i), 7'(i), NOP_WORD});
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 300 && !bus.in_ready; i++) tick;
    check("clear_drain", exp_q.size(), 0);
    check("load_status", {busy, cpu_hold, done, bus.in_ready}, 4'b1101);
  endtask
  task automatic send(input logic [7:0] d, input logic l, input int gap);
    repeat (gap) tick;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    tick;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input logic [6:0] addr, input logic l, input logic wr, input int maxgap);
    for (int b = 0; b < 4; b++) send(w[8*b +: 8], l && b == 3, int'($urandom_range(maxgap, 0)));
    if (wr) exp_q.push_back({32'(cyc), addr, w});
  endtask
  task automatic wait_done;
    for (int i = 0; i < 20 && !done; i++) tick;
  endtask
  task automatic check_idle_outs(input string tag);
    check(tag, {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_hold, done, err, word_count}, '0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    repeat (3) tick;
    check_idle_outs("reset_outs");
    reset = 1'b0;
    tick;
    check_idle_outs("idle_outs");
    do_start;
    send_word(32'h0050_0093, 7'd0, 1'b1, 1'b1, 0);
    wait_done;
    check("single_status", {done, err, word_count, cpu_hold, busy}, {1'b1, 1'b0, 8'd1, 1'b0, 1'b0});
    check("single_drain", exp_q.size(), 0);
    do_start;
    send_word(32'hDEAD_BEEF, 7'd0, 1'b0, 1'b1, 3);
    send_word(32'h1234_5678, 7'd1, 1'b0, 1'b1, 3);
    send_word(32'hCAFE_F00D, 7'd2, 1'b1, 1'b1, 3);
    wait_done;
    check("gaps_status", {done, err, word_count}, {1'b1, 1'b0, 8'd3});
    check("gaps_drain", exp_q.size(), 0);
    do_start;
    send_word(32'hA1B2_C3D4, 7'd0, 1'b0, 1'b1, 0);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b1, 0);
    wait_done;
    check("partial_status", {done, err, word_count}, {1'b1, 1'b1, 8'd1});
    check("partial_drain", exp_q.size(), 0);
    do_start;
    for (int i = 0; i <= IMEM_DEPTH; i++)
      send_word((32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000, 7'(i), i == IMEM_DEPTH, i < IMEM_DEPTH, 0);
    wait_done;
    check("ovf_status", {done, err, word_count}, {1'b1, 1'b1, 8'd128});
    repeat (3) tick;
    check("ovf_drain", exp_q.size(), 0);
    check("ovf_hold", {done, err, word_count, bus.in_ready}, {1'b1, 1'b1, 8'd128, 1'b0});
    do_start;
    send_word(32'h0111_0111, 7'd0, 1'b0, 1'b1, 0);
    send_word(32'h0222_0222, 7'd1, 1'b0, 1'b1, 0);
    check("pre_reset_count", word_count, 2);
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    reset = 1'b1;
    #1;
    check_idle_outs("abort_outs");
    check("abort_drain", exp_q.size(), 0);
    tick;
    reset = 1'b0;
    tick;
    do_start;
    send_word(32'h0333_0333, 7'd0, 1'b1, 1'b1, 0);
    wait_done;
    check("restart_status", {done, err, word_count}, {1'b1, 1'b0, 8'd1});
    check("restart_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
